// File: rtl/simple_stim_sequencer_pkg.sv
// Shared types for the simple_dpi operand feeder: FSM states, config addresses
// and the buffered operand-pair layout.
package simple_stim_pkg;

    localparam int unsigned PAIR_DATA_W = 8;

    localparam logic CFG_ADDR_OPT1_F = 1'b0;
    localparam logic CFG_ADDR_VALID  = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    typedef struct packed {
        logic [PAIR_DATA_W-1:0] arg1;
        logic [PAIR_DATA_W-1:0] arg2;
    } pair_t;

endpackage

// File: rtl/simple_stim_sequencer_fifo.sv
// Synchronous operand-pair FIFO with registered full/empty flags and fill level.
// A written entry becomes poppable one edge after the edge that wrote it.
module simple_stim_fifo
    import simple_stim_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned LW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  pair_t         wr_data,
    output pair_t         rd_data,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    pair_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic [LW-1:0] older;
    logic [LW-1:0] count_next;

    // Entries already present before this edge that survive its pop; only
    // these may be popped on the following edge.
    assign older      = count - LW'(pop);
    assign count_next = older + LW'(push);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == LW'(DEPTH));
            empty <= (older == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign level   = count;

endmodule

// File: rtl/simple_stim_sequencer.sv
// Feeds buffered operand pairs to simple_dpi for HOLD_CYCLES enabled cycles each and
// commits shadowed parameter writes only on a pair boundary.
module simple_stim_sequencer
    import simple_stim_pkg::*;
#(
    parameter int unsigned DATA_W      = PAIR_DATA_W,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned HOLD_CYCLES = 1,
    localparam int unsigned LW = $clog2(FIFO_DEPTH + 1),
    localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_arg1,
    input  logic [DATA_W-1:0] s_arg2,
    input  logic              cfg_we,
    input  logic              cfg_addr,
    input  logic [DATA_W-1:0] cfg_wdata,
    input  logic              cfg_commit,
    output logic              clk_enable,
    output logic [DATA_W-1:0] inputArg1,
    output logic [DATA_W-1:0] inputArg2,
    output logic [DATA_W-1:0] opt1_f,
    output logic              param_valid,
    output logic [LW-1:0]     level
);

    state_t            state, state_next;
    logic [CW-1:0]     cnt, cnt_next;
    logic              ce_next;
    logic [DATA_W-1:0] arg1_next, arg2_next;
    logic              ready_en, full, empty, push, pop, apply;
    logic [DATA_W-1:0] shadow_opt1_f;
    logic              shadow_valid, commit_pending;
    pair_t             wr_pair, head;

    assign s_ready = ready_en & ~full;
    assign push    = s_valid & s_ready;
    assign wr_pair = '{arg1: s_arg1, arg2: s_arg2};

    simple_stim_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_pair),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ce_next    = clk_enable;
        arg1_next  = inputArg1;
        arg2_next  = inputArg2;
        pop        = 1'b0;
        unique case (state)
            IDLE: pop = ~empty;
            HOLD: begin
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else if (!empty) begin
                    pop = 1'b1;
                end else begin
                    ce_next    = 1'b0;
                    state_next = IDLE;
                end
            end
        endcase
        if (pop) begin
            arg1_next  = head.arg1;
            arg2_next  = head.arg2;
            ce_next    = 1'b1;
            cnt_next   = CW'(HOLD_CYCLES - 1);
            state_next = HOLD;
        end
    end

    // A pending commit rides on the next pop, or lands at once when idle.
    assign apply = commit_pending & (pop | (state == IDLE));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            cnt            <= '0;
            clk_enable     <= 1'b0;
            inputArg1      <= '0;
            inputArg2      <= '0;
            ready_en       <= 1'b0;
            opt1_f         <= '0;
            param_valid    <= 1'b0;
            shadow_opt1_f  <= '0;
            shadow_valid   <= 1'b0;
            commit_pending <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            clk_enable <= ce_next;
            inputArg1  <= arg1_next;
            inputArg2  <= arg2_next;
            ready_en   <= 1'b1;
            if (apply) begin
                opt1_f      <= shadow_opt1_f;
                param_valid <= shadow_valid;
            end
            if (cfg_we) begin
                if (cfg_addr == CFG_ADDR_OPT1_F) shadow_opt1_f <= cfg_wdata;
                else                             shadow_valid  <= cfg_wdata[0];
            end
            commit_pending <= cfg_commit | (commit_pending & ~apply);
        end
    end

endmodule

// File: tb/tb_simple_stim_sequencer.sv
// Bench for simple_stim_sequencer: two instances (hold 1 and hold 3) driven by the
// same stimulus, each compared every cycle against a transaction-level model.
module tb_simple_stim_sequencer;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int LW    = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          s_valid;
    logic [DW-1:0] s_arg1, s_arg2;
    logic          cfg_we, cfg_addr, cfg_commit;
    logic [DW-1:0] cfg_wdata;

    logic          ready_o [2];
    logic          ce_o    [2];
    logic [DW-1:0] a1_o    [2];
    logic [DW-1:0] a2_o    [2];
    logic [DW-1:0] opt_o   [2];
    logic          pv_o    [2];
    logic [LW-1:0] lvl_o   [2];

    int n_checks;
    int n_errors;

    always #5 clk = ~clk;

    simple_stim_sequencer #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .HOLD_CYCLES(1)) dut_h1 (
        .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(ready_o[0]),
        .s_arg1(s_arg1), .s_arg2(s_arg2), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit), .clk_enable(ce_o[0]),
        .inputArg1(a1_o[0]), .inputArg2(a2_o[0]), .opt1_f(opt_o[0]),
        .param_valid(pv_o[0]), .level(lvl_o[0])
    );

    simple_stim_sequencer #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .HOLD_CYCLES(3)) dut_h3 (
        .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(ready_o[1]),
        .s_arg1(s_arg1), .s_arg2(s_arg2), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit), .clk_enable(ce_o[1]),
        .inputArg1(a1_o[1]), .inputArg2(a2_o[1]), .opt1_f(opt_o[1]),
        .param_valid(pv_o[1]), .level(lvl_o[1])
    );

    // Model state: a circular list of queued pairs, how many of them are old
    // enough to be taken, the pair on show and its remaining hold cycles.
    logic [DW-1:0] q1 [2][16];
    logic [DW-1:0] q2 [2][16];
    int            qhead [2];
    int            qsize [2];
    int            qseen [2];
    bit            busy  [2];
    int            left  [2];
    bit            started [2];
    logic [DW-1:0] m_a1 [2], m_a2 [2], m_opt [2], m_sh_opt [2];
    bit            m_ce [2], m_pv [2], m_sh_pv [2], m_pend [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic string nm(input int m, input string sig);
        return {(m == 0) ? "h1." : "h3.", sig};
    endfunction

    task automatic model_reset(input int m);
        qhead[m] = 0; qsize[m] = 0; qseen[m] = 0; busy[m] = 0; left[m] = 0;
        started[m] = 0; m_a1[m] = '0; m_a2[m] = '0; m_opt[m] = '0; m_sh_opt[m] = '0;
        m_ce[m] = 0; m_pv[m] = 0; m_sh_pv[m] = 0; m_pend[m] = 0;
    endtask

    task automatic model_step(input int m);
        int  hold  = (m == 0) ? 1 : 3;
        bit  take  = s_valid && started[m] && (qsize[m] < DEPTH);
        bit  show  = (qseen[m] > 0) && (!busy[m] || left[m] == 0);
        bit  apply = m_pend[m] && (show || !busy[m]);
        int  tail  = (qhead[m] + qsize[m]) % 16;
        if (take) begin
            q1[m][tail] = s_arg1;
            q2[m][tail] = s_arg2;
        end
        if (show) begin
            m_a1[m] = q1[m][qhead[m]];
            m_a2[m] = q2[m][qhead[m]];
            qhead[m] = (qhead[m] + 1) % 16;
            busy[m] = 1; m_ce[m] = 1; left[m] = hold - 1;
        end else if (busy[m]) begin
            if (left[m] > 0) left[m]--;
            else begin busy[m] = 0; m_ce[m] = 0; end
        end
        if (apply) begin
            m_opt[m] = m_sh_opt[m];
            m_pv[m]  = m_sh_pv[m];
        end
        if (cfg_we) begin
            if (cfg_addr) m_sh_pv[m] = cfg_wdata[0];
            else          m_sh_opt[m] = cfg_wdata;
        end
        m_pend[m]  = cfg_commit || (m_pend[m] && !apply);
        qseen[m]   = qsize[m] - int'(show);
        qsize[m]   = qsize[m] - int'(show) + int'(take);
        started[m] = 1;
    endtask

    task automatic check_all();
        for (int m = 0; m < 2; m++) begin
            check_eq(nm(m, "s_ready"),     32'(ready_o[m]), 32'(started[m] && qsize[m] < DEPTH));
            check_eq(nm(m, "clk_enable"),  32'(ce_o[m]),    32'(m_ce[m]));
            check_eq(nm(m, "inputArg1"),   32'(a1_o[m]),    32'(m_a1[m]));
            check_eq(nm(m, "inputArg2"),   32'(a2_o[m]),    32'(m_a2[m]));
            check_eq(nm(m, "opt1_f"),      32'(opt_o[m]),   32'(m_opt[m]));
            check_eq(nm(m, "param_valid"), 32'(pv_o[m]),    32'(m_pv[m]));
            check_eq(nm(m, "level"),       32'(lvl_o[m]),   32'(qsize[m]));
        end
    endtask

    task automatic check_zero(input string tag);
        for (int m = 0; m < 2; m++) begin
            check_eq(nm(m, {tag, ".s_ready"}),    32'(ready_o[m]), 32'h0);
            check_eq(nm(m, {tag, ".clk_enable"}), 32'(ce_o[m]),    32'h0);
            check_eq(nm(m, {tag, ".args"}),       32'({a1_o[m], a2_o[m]}), 32'h0);
            check_eq(nm(m, {tag, ".opt1_f"}),     32'(opt_o[m]),   32'h0);
            check_eq(nm(m, {tag, ".param_valid"}), 32'(pv_o[m]),   32'h0);
            check_eq(nm(m, {tag, ".level"}),      32'(lvl_o[m]),   32'h0);
        end
    endtask

    // Drive at the falling edge, advance one rising edge, compare 1 ns later.
    task automatic cycle(input logic v, input logic [DW-1:0] x1, input logic [DW-1:0] x2,
                         input logic we, input logic ad, input logic [DW-1:0] wd, input logic cm);
        s_valid = v; s_arg1 = x1; s_arg2 = x2;
        cfg_we = we; cfg_addr = ad; cfg_wdata = wd; cfg_commit = cm;
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (!reset_n) model_reset(m);
            else          model_step(m);
        end
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, '0, '0, 0, 0, '0, 0);
    endtask

    task automatic random_cycles(input int n);
        for (int i = 0; i < n; i++)
            cycle($urandom_range(0, 99) < 60, DW'($urandom), DW'($urandom),
                  $urandom_range(0, 99) < 15, 1'($urandom), DW'($urandom),
                  $urandom_range(0, 99) < 10);
    endtask

    logic [DW-1:0] p1 [6];
    logic [DW-1:0] p2 [6];
    logic          ce_log [12];
    logic [DW-1:0] a1_log [12];
    logic [DW-1:0] a2_log [12];

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        s_valid = 0; s_arg1 = '0; s_arg2 = '0;
        cfg_we = 0; cfg_addr = 0; cfg_wdata = '0; cfg_commit = 0;
        for (int m = 0; m < 2; m++) model_reset(m);
        #3;
        check_zero("por");
        @(negedge clk);
        reset_n = 1'b1;
        idle(1);
        for (int m = 0; m < 2; m++) check_eq(nm(m, "ready_after_release"), 32'(ready_o[m]), 32'h1);

        // Single pair: enabled two edges after the push, then disabled with args held.
        cycle(1, 8'h08, 8'h01, 0, 0, '0, 0);
        check_eq("h1.lat_n0_ce", 32'(ce_o[0]), 32'h0);
        idle(1);
        check_eq("h1.lat_n1_ce", 32'(ce_o[0]), 32'h0);
        idle(1);
        check_eq("h1.lat_n2_ce", 32'(ce_o[0]), 32'h1);
        check_eq("h1.lat_n2_args", 32'({a1_o[0], a2_o[0]}), 32'h0801);
        idle(1);
        check_eq("h1.lat_n3_ce", 32'(ce_o[0]), 32'h0);
        check_eq("h1.lat_n3_args", 32'({a1_o[0], a2_o[0]}), 32'h0801);
        idle(6);

        // Burst: back-to-back enabled cycles on h1, h3 fills and refuses.
        p1 = '{8'h08, 8'h10, 8'h30, 8'h70, 8'h11, 8'h22};
        p2 = '{8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 8'h07};
        for (int i = 0; i < 12; i++) begin
            if (i < 6) cycle(1, p1[i], p2[i], 0, 0, '0, 0);
            else       idle(1);
            ce_log[i] = ce_o[0]; a1_log[i] = a1_o[0]; a2_log[i] = a2_o[0];
            if (i == 4) begin
                check_eq("h3.burst_level_full", 32'(lvl_o[1]), 32'h4);
                check_eq("h3.burst_refuse", 32'(ready_o[1]), 32'h0);
            end
        end
        for (int i = 2; i < 8; i++) begin
            check_eq("h1.burst_ce", 32'(ce_log[i]), 32'h1);
            check_eq("h1.burst_args", 32'({a1_log[i], a2_log[i]}), 32'({p1[i-2], p2[i-2]}));
        end
        check_eq("h1.burst_end_ce", 32'(ce_log[8]), 32'h0);
        idle(20);

        // Parameter commit lands on the edge that shows the next pair.
        cycle(1, 8'h21, 8'h22, 0, 0, '0, 0);
        cycle(1, 8'h31, 8'h32, 1, 0, 8'h02, 0);
        cycle(0, '0, '0, 0, 0, '0, 1);
        check_eq("h1.commit_early_opt", 32'(opt_o[0]), 32'h0);
        check_eq("h1.commit_early_arg", 32'(a1_o[0]), 32'h21);
        idle(1);
        check_eq("h1.commit_opt", 32'(opt_o[0]), 32'h02);
        check_eq("h1.commit_arg", 32'(a1_o[0]), 32'h31);
        idle(12);

        // Valid toggling while idle: each commit takes effect one edge later.
        for (int k = 0; k < 5; k++) begin
            logic v;
            v = (k % 2 == 0);
            cycle(0, '0, '0, 1, 1, DW'(v), 1);
            for (int m = 0; m < 2; m++)
                check_eq(nm(m, "pv_before"), 32'(pv_o[m]), 32'(k == 0 ? 1'b0 : !v));
            idle(1);
            for (int m = 0; m < 2; m++)
                check_eq(nm(m, "pv_after"), 32'(pv_o[m]), 32'(v));
        end
        idle(2);

        // Hold of 3: two pairs, three enabled cycles each, no gap.
        for (int i = 0; i < 11; i++) begin
            if (i == 0)      cycle(1, 8'h08, 8'h07, 0, 0, '0, 0);
            else if (i == 1) cycle(1, 8'h10, 8'h08, 0, 0, '0, 0);
            else             idle(1);
            ce_log[i] = ce_o[1]; a1_log[i] = a1_o[1]; a2_log[i] = a2_o[1];
        end
        for (int i = 2; i < 8; i++) begin
            check_eq("h3.hold_ce", 32'(ce_log[i]), 32'h1);
            check_eq("h3.hold_args", 32'({a1_log[i], a2_log[i]}), (i < 5) ? 32'h0807 : 32'h1008);
        end
        check_eq("h3.hold_end_ce", 32'(ce_log[8]), 32'h0);

        random_cycles(400);

        // Reset mid-run with pairs queued and an uncommitted shadow.
        for (int i = 0; i < 3; i++) cycle(1, DW'($urandom), DW'($urandom), 0, 0, '0, 0);
        cycle(1, 8'h5A, 8'hA5, 1, 0, 8'hA5, 0);
        cycle(0, '0, '0, 1, 1, 8'h01, 0);
        reset_n = 1'b0;
        #1;
        check_zero("midrst");
        for (int m = 0; m < 2; m++) model_reset(m);
        idle(2);
        reset_n = 1'b1;
        idle(1);
        for (int m = 0; m < 2; m++) check_eq(nm(m, "ready_after_midrst"), 32'(ready_o[m]), 32'h1);
        cycle(0, '0, '0, 0, 0, '0, 1);
        idle(1);
        for (int m = 0; m < 2; m++) begin
            check_eq(nm(m, "shadow_lost_opt"), 32'(opt_o[m]), 32'h0);
            check_eq(nm(m, "shadow_lost_pv"), 32'(pv_o[m]), 32'h0);
        end

        random_cycles(300);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
